// File: rtl/fb_fill_dma.sv
// fb_fill_dma: bus-master fill engine for the shared framebuffer RAM.
// The CPU programs destination, word count, pattern and step, then sets start.
// The engine requests the bus with hold. Once busy grants it, the engine writes
// one word per granted clock. Grants are capped at BURST words and separated by
// GAP idle cycles so the CPU keeps making progress. A done pulse marks the end
// of each job, whether it completed or was aborted.
module fb_fill_dma #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16,
    parameter int BURST  = 32,
    parameter int GAP    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reg_we,
    input  logic [1:0]        reg_addr,
    input  logic [DATA_W-1:0] reg_wdata,
    output logic [DATA_W-1:0] status,
    output logic              hold,
    input  logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WRITE,
        S_RELEASE,
        S_GAP
    } state_t;

    // Terminal values for the burst and gap counters. When GAP is 0, the GAP
    // state is never entered, so the wrapped value of GAP_LAST is never used.
    localparam logic [15:0] BURST_LAST = 16'(BURST - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP - 1);

    state_t            state;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] count;
    logic [DATA_W-1:0] pattern;
    logic [7:0]        step;
    logic              inc;
    logic [15:0]       burst_cnt;
    logic [15:0]       gap_cnt;
    logic              abort;

    // A CTRL write with start clear cancels a running job.
    assign abort = reg_we && (reg_addr == 2'd3) && !reg_wdata[0];

    // Write strobe follows busy directly, so a dropped grant stops writes in
    // the same cycle.
    assign mem_we    = (state == S_WRITE) && busy;
    assign mem_addr  = dst;
    assign mem_wdata = pattern;
    assign status    = {state != S_IDLE, count};

    // Job sequencer. Holds the programming registers and drives the registered
    // outputs hold and done.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            dst       <= '0;
            count     <= '0;
            pattern   <= '0;
            step      <= '0;
            inc       <= 1'b0;
            burst_cnt <= '0;
            gap_cnt   <= '0;
            hold      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (reg_we) begin
                        case (reg_addr)
                            2'd0: dst     <= reg_wdata[ADDR_W-1:0];
                            2'd1: count   <= reg_wdata[ADDR_W-1:0];
                            2'd2: pattern <= reg_wdata;
                            default: begin
                                inc  <= reg_wdata[1];
                                step <= reg_wdata[15:8];
                                if (reg_wdata[0]) begin
                                    // An empty job completes immediately and
                                    // never touches the bus.
                                    if (count != '0) begin
                                        state     <= S_REQ;
                                        hold      <= 1'b1;
                                        burst_cnt <= '0;
                                    end else begin
                                        done <= 1'b1;
                                    end
                                end
                            end
                        endcase
                    end
                end

                S_REQ: begin
                    if (abort) begin
                        count <= '0;
                        state <= S_RELEASE;
                        hold  <= 1'b0;
                    end else if (busy) begin
                        state <= S_WRITE;
                    end
                end

                S_WRITE: begin
                    // A word granted in the abort cycle still completes.
                    if (busy) begin
                        dst       <= dst + ADDR_W'(step);
                        count     <= count - ADDR_W'(1);
                        pattern   <= pattern + DATA_W'(inc);
                        burst_cnt <= burst_cnt + 16'd1;
                    end
                    if (abort) begin
                        count <= '0;
                        state <= S_RELEASE;
                        hold  <= 1'b0;
                    end else if (busy && (count == ADDR_W'(1) || burst_cnt == BURST_LAST)) begin
                        state <= S_RELEASE;
                        hold  <= 1'b0;
                    end
                end

                S_RELEASE: begin
                    // Wait until the CPU has actually taken the bus back.
                    if (!busy) begin
                        if (count == '0) begin
                            done  <= 1'b1;
                            state <= S_IDLE;
                        end else begin
                            burst_cnt <= '0;
                            gap_cnt   <= '0;
                            if (GAP == 0) begin
                                state <= S_REQ;
                                hold  <= 1'b1;
                            end else begin
                                state <= S_GAP;
                            end
                        end
                    end
                end

                S_GAP: begin
                    if (abort) begin
                        count <= '0;
                        state <= S_RELEASE;
                    end else if (gap_cnt == GAP_LAST) begin
                        state <= S_REQ;
                        hold  <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    hold  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_fill_dma.sv
// Bench for fb_fill_dma. The CPU side is modelled with busy following hold one
// cycle late. Expected writes come from the closed-form job definition, which
// gives address dst+i*step and data pat+i*inc for word i.
module tb_fb_fill_dma;

    localparam int BURST = 32;
    localparam int GAP   = 8;

    logic        clk;
    logic        reset;
    logic        reg_we;
    logic [1:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [15:0] status;
    logic        hold;
    logic        busy;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        done;

    fb_fill_dma #(.ADDR_W(15), .DATA_W(16), .BURST(BURST), .GAP(GAP)) dut (
        .clk(clk), .reset(reset), .reg_we(reg_we), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .status(status), .hold(hold), .busy(busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [14:0] exp_addr[$];
    logic [15:0] exp_data[$];
    logic [14:0] log_addr[$];
    logic [15:0] log_data[$];
    int          log_cyc[$];
    int          grant_q[$];
    logic [15:0] ram [0:32767];

    int   cyc = 0, writes_total = 0, done_cnt = 0, hold_rises = 0;
    int   burst_run = 0, low_run = 0, grants_in_job = 0;
    logic prev_hold = 1'b0, hold_d = 1'b0, pause = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // CPU grant: busy mirrors the previous cycle's hold unless a stall is forced.
    initial begin
        busy = 1'b0;
        forever begin
            @(posedge clk);
            #1 busy = hold_d & ~pause;
        end
    end

    // Compare process: each write against the model, plus bus-protocol tracking.
    always @(negedge clk) begin
        logic [14:0] ea;
        logic [15:0] ed;
        cyc++;
        hold_d = hold;
        if (mem_we) begin
            chk("we_without_hold", hold, 1);
            if (exp_addr.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_addr, mem_wdata);
            end else begin
                ea = exp_addr.pop_front();
                ed = exp_data.pop_front();
                chk("wr_addr", mem_addr, ea);
                chk("wr_data", mem_wdata, ed);
            end
            ram[mem_addr] = mem_wdata;
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
            log_cyc.push_back(cyc);
            writes_total++;
            burst_run++;
            if (burst_run > BURST) chk("burst_cap", burst_run, BURST);
        end
        if (hold && !prev_hold) begin
            hold_rises++;
            if (grants_in_job > 0) chk("gap_len_ok", low_run >= GAP, 1);
            burst_run = 0;
        end
        if (!hold && prev_hold) begin
            grant_q.push_back(burst_run);
            grants_in_job++;
            low_run = 0;
        end
        if (!hold) low_run++;
        if (done) done_cnt++;
        prev_hold = hold;
    end

    task automatic nclk();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        reg_we = 1'b1; reg_addr = a; reg_wdata = d;
        @(posedge clk);
        #1 reg_we = 1'b0;
    endtask

    task automatic start_job(input int dst, input int cnt, input int pat, input logic [15:0] ctrl);
        int st, in;
        st = int'(ctrl[15:8]);
        in = int'(ctrl[1]);
        log_addr.delete(); log_data.delete(); log_cyc.delete(); grant_q.delete();
        grants_in_job = 0;
        for (int i = 0; i < cnt; i++) begin
            exp_addr.push_back(15'(dst + i * st));
            exp_data.push_back(16'(pat + i * in));
        end
        wr(2'd0, 16'(dst));
        wr(2'd1, 16'(cnt));
        wr(2'd2, 16'(pat));
        wr(2'd3, ctrl);
    endtask

    task automatic wait_done(input string name, input int bound);
        int s, n;
        s = done_cnt;
        n = 0;
        while (done_cnt == s && n < bound) begin
            nclk();
            n++;
        end
        chk(name, done_cnt > s, 1);
    endtask

    task automatic wait_writes(input string name, input int target, input int bound);
        int n;
        n = 0;
        while (log_addr.size() < target && n < bound) begin
            nclk();
            n++;
        end
        chk(name, log_addr.size() >= target, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0, w0, ws, n;
        logic [14:0] t3 [4];
        reset = 1'b0; reg_we = 1'b0; reg_addr = 2'd0; reg_wdata = 16'h0;
        repeat (3) @(posedge clk);
        nclk();
        chk("rst_status", status, 0);
        chk("rst_hold", hold, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_done", done, 0);
        reset = 1'b1;
        nclk();

        // 1: four-word fill of a constant pattern
        d0 = done_cnt;
        start_job(32'h1000, 4, 32'hAAAA, 16'h0101);
        nclk();
        chk("t1_hold_latency", hold, 1);
        chk("t1_active", status[15], 1);
        wait_done("t1_done", 100);
        chk("t1_done_high", done, 1);
        chk("t1_status", status, 0);
        chk("t1_hold_off", hold, 0);
        chk("t1_nwr", log_addr.size(), 4);
        for (int i = 0; i < log_addr.size() && i < 4; i++) begin
            chk("t1_addr", log_addr[i], 32'h1000 + i);
            chk("t1_data", log_data[i], 32'hAAAA);
            chk("t1_consecutive", log_cyc[i] - log_cyc[0], i);
        end
        nclk();
        chk("t1_done_pulse_width", done, 0);
        chk("t1_done_count", done_cnt - d0, 1);
        chk("t1_left", exp_addr.size(), 0);

        // 2: 70 words split across three grants
        d0 = done_cnt;
        start_job(32'h0100, 70, 0, 16'h0103);
        wait_done("t2_done", 3000);
        chk("t2_grants", grant_q.size(), 3);
        if (grant_q.size() == 3) begin
            chk("t2_grant0", grant_q[0], 32);
            chk("t2_grant1", grant_q[1], 32);
            chk("t2_grant2", grant_q[2], 6);
        end
        for (int i = 0; i < 70; i++) chk("t2_ram", ram[15'h0100 + 15'(i)], i);
        chk("t2_done_count", done_cnt - d0, 1);
        chk("t2_left", exp_addr.size(), 0);

        // 3: address wrap at the top of RAM
        start_job(32'h7FFE, 4, 32'h1234, 16'h0101);
        wait_done("t3_done", 100);
        t3[0] = 15'h7FFE; t3[1] = 15'h7FFF; t3[2] = 15'h0000; t3[3] = 15'h0001;
        chk("t3_nwr", log_addr.size(), 4);
        for (int i = 0; i < log_addr.size() && i < 4; i++) begin
            chk("t3_addr", log_addr[i], t3[i]);
            chk("t3_data", log_data[i], 32'h1234);
        end
        chk("t3_left", exp_addr.size(), 0);

        // 4: grant withdrawn for three cycles after word 5, with step 2 and incrementing data
        start_job(32'h0400, 10, 32'h0050, 16'h0203);
        wait_writes("t4_reach5", 5, 100);
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nclk();
            chk("t4_pause_hold", hold, 1);
            chk("t4_pause_we", mem_we, 0);
        end
        pause = 1'b0;
        wait_done("t4_done", 200);
        chk("t4_nwr", log_addr.size(), 10);
        if (log_addr.size() > 5) begin
            chk("t4_resume_addr", log_addr[5], 32'h040A);
            chk("t4_resume_data", log_data[5], 32'h0055);
        end
        chk("t4_one_grant", grant_q.size(), 1);
        chk("t4_left", exp_addr.size(), 0);

        // 5a: empty job pulses done without requesting the bus
        d0 = done_cnt;
        r0 = hold_rises;
        start_job(0, 0, 0, 16'h0001);
        nclk();
        chk("t5_empty_done", done, 1);
        chk("t5_empty_hold", hold, 0);
        repeat (10) nclk();
        chk("t5_empty_no_hold", hold_rises - r0, 0);
        chk("t5_empty_done_count", done_cnt - d0, 1);

        // 5b: abort while 20 words remain
        d0 = done_cnt;
        ws = writes_total;
        start_job(32'h0800, 40, 0, 16'h0103);
        n = 0;
        while (!(status[14:0] == 15'd20 && mem_we) && n < 500) begin
            nclk();
            n++;
        end
        chk("t5_reach20", status[14:0], 20);
        wr(2'd3, 16'h0000);
        w0 = writes_total;
        chk("t5_abort_hold", hold, 0);
        wait_done("t5_abort_done", 100);
        chk("t5_no_more_writes", writes_total, w0);
        chk("t5_at_most_one", (writes_total - ws) <= 21 && (writes_total - ws) >= 20, 1);
        chk("t5_abort_status", status, 0);
        chk("t5_abort_done_count", done_cnt - d0, 1);
        exp_addr.delete();
        exp_data.delete();

        // 6: reset in the middle of a burst
        start_job(32'h2000, 30, 32'h5555, 16'h0101);
        wait_writes("t6_reach5", 5, 100);
        reset = 1'b0;
        @(posedge clk);
        #1 w0 = writes_total;
        nclk();
        chk("t6_hold", hold, 0);
        chk("t6_we", mem_we, 0);
        chk("t6_status", status, 0);
        nclk();
        reset = 1'b1;
        repeat (10) nclk();
        chk("t6_no_writes", writes_total, w0);
        chk("t6_idle_status", status, 0);
        exp_addr.delete();
        exp_data.delete();

        // fresh job after reset with step 3
        start_job(32'h3000, 5, 32'h0F0F, 16'h0301);
        wait_done("t6_fresh_done", 100);
        chk("t6_fresh_nwr", log_addr.size(), 5);
        if (log_addr.size() == 5) chk("t6_fresh_last_addr", log_addr[4], 32'h300C);
        chk("t6_fresh_left", exp_addr.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fb_fill_dma.md
Name: fb_fill_dma

Overview:
Bus-master write engine for the shared 15-bit-address framebuffer RAM. It is the write-side counterpart of the video line-fetch DMA. The CPU programs a destination, word count, pattern and step through four registers. The block then requests the bus with hold, waits for the CPU's busy acknowledge, and writes one 16-bit word per clock. Bursts are capped so that the CPU is never starved, and a done pulse is raised at completion.

Parameters:
ADDR_W, 15, RAM word-address width.
DATA_W, 16, RAM/register data width.
BURST, 32, maximum words written per hold grant (must be ≥1).
GAP, 8, idle cycles with hold=0 between bursts (0 = re-request immediately).

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-low (0 = reset), sampled on posedge clk.
reg_we  in  1  register write strobe from CPU decode.
reg_addr  in  2  0=DST, 1=COUNT, 2=PATTERN, 3=CTRL.
reg_wdata  in  16  register write data.
status  out  16  {active, remaining_count[14:0]}.
hold  out  1  bus request to CPU.
busy  in  1  CPU has released the bus (grant).
mem_addr  out  15  RAM write address.
mem_wdata  out  16  RAM write data.
mem_we  out  1  RAM write enable.
done  out  1  one-cycle pulse when a job completes or aborts.

Behaviour:
- Reset (reset=0 at posedge): state=IDLE; hold=0, mem_we=0, done=0, status=0; DST, COUNT, PATTERN, CTRL, burst counter and gap counter all 0. A reset mid-transfer drops hold at that edge; no further writes are made.
- Registers are writable only in IDLE. Writes in any other state are ignored, except the CTRL abort below. DST takes reg_wdata[14:0]. COUNT takes reg_wdata[14:0]. PATTERN takes all 16 bits. CTRL: bit0=start (self-clearing, never stored), bit1=INC (pattern+1 after each word), bits15:8=STEP.
- States: IDLE, REQ, WRITE, RELEASE, GAP.
- IDLE: a CTRL write with bit0=1 and COUNT≠0 moves to REQ next edge. With COUNT=0 the block stays IDLE, pulses done next cycle, and never asserts hold.
- REQ: hold=1. Move to WRITE on the first edge where busy=1.
- WRITE: hold=1. mem_we = busy (combinational), mem_addr=DST, mem_wdata=PATTERN.
  - On each edge with busy=1: DST += STEP (mod 2^15, wrap silently), COUNT -= 1, PATTERN += INC (mod 2^16), burst counter += 1.
  - If busy drops mid-burst: mem_we=0 and the block pauses in WRITE with hold still 1; it resumes when busy returns.
  - Exit to RELEASE on the edge that writes the last word (COUNT 1→0) or the BURST-th word of the grant.
- RELEASE: hold=0, mem_we=0. Wait for busy=0.
  - Then, if COUNT=0, pulse done and go to IDLE.
  - Otherwise clear the burst counter and go to GAP (or directly to REQ if GAP=0).
- GAP: hold=0. Count GAP cycles, then go to REQ.
- Abort: a CTRL write with bit0=0 in REQ, WRITE or GAP forces COUNT=0 and goes to RELEASE. A word being written in that same cycle still completes. done then pulses as a normal completion.
- A CTRL start written while not IDLE is ignored.
- Latency: start write at edge N → hold=1 during cycle N+1. If busy is already 1, the first mem_we is in cycle N+2.
- status[15] = (state≠IDLE). status[14:0] = COUNT. Both are registered.
- mem_addr and mem_wdata are driven continuously; the RAM must qualify on mem_we only.

Test Plan:
1. DST=0x1000, COUNT=4, PATTERN=0xAAAA, CTRL=0x0101, busy follows hold with 1-cycle lag → writes 0xAAAA at 0x1000..0x1003 on 4 consecutive cycles; hold drops; done pulses once; status=0.
2. COUNT=70, BURST=32, GAP=8, STEP=1, INC=1, PATTERN=0 → three grants of 32/32/6 words; hold low ≥8 cycles between grants; RAM[DST+i]=i for i=0..69.
3. DST=0x7FFE, COUNT=4, STEP=1 → writes land at 0x7FFE, 0x7FFF, 0x0000, 0x0001.
4. busy deasserted for 3 cycles mid-burst after word 5 of 10 → mem_we=0 for those 3 cycles, hold stays 1; words 6–10 resume at the correct addresses; exactly 10 writes in total.
5. COUNT=0 start → hold never rises, done pulses in the next cycle. Separately, CTRL=0x0000 written during WRITE with 20 words remaining → at most 1 further write, then hold=0, done=1.
6. reset=0 asserted mid-WRITE → next cycle hold=0, mem_we=0, status=0; no writes thereafter; a fresh job after reset runs normally.
